// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one buart transmit channel between N requesters.
// A grant is held for a whole message (up to the byte flagged last) or until an idle timeout.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    input  logic             uart_busy,
    output logic             uart_wr,
    output logic [7:0]       uart_tx_data,
    output logic [IDW-1:0]   owner,
    output logic             owner_valid,
    output logic             lock_timeout
);

    // Handshake: byte i moves in any cycle where req_valid[i] & req_ready[i] at posedge clk;
    // valid/data/last must stay stable until that cycle, and ready never depends on other requesters.

    localparam int             TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDW:0]   NN    = (IDW + 1)'(N);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   next_ptr;
    logic [IDW:0]     scan;
    logic [1:0]       guard_cnt;
    logic [TW-1:0]    tcnt;
    logic             guard;
    logic             any_req;
    logic             own_valid;
    logic             own_last;
    logic [7:0]       own_data;
    logic             accept;
    logic             idle_cycle;

    assign guard     = (guard_cnt != 2'd0);
    assign any_req   = |req_valid;
    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign own_data  = req_data[{owner, 3'b000} +: 8];
    assign next_ptr  = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;

    // Lowest offset from rr_ptr wins, so scan offsets from the top down and let later hits override.
    always_comb begin
        winner = '0;
        scan   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (scan >= NN) scan = scan - NN;
            if (req_valid[scan[IDW-1:0]]) winner = scan[IDW-1:0];
        end
    end

    always_comb begin
        req_ready = '0;
        if (resetq && state == SEND && !uart_busy && !guard) req_ready[owner] = 1'b1;
    end

    assign accept     = own_valid & req_ready[owner];
    assign idle_cycle = (state == SEND) & ~own_valid & ~uart_busy & ~guard;

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            owner_valid  <= 1'b0;
            uart_wr      <= 1'b0;
            uart_tx_data <= 8'h00;
            lock_timeout <= 1'b0;
            guard_cnt    <= 2'd0;
            tcnt         <= '0;
        end else begin
            uart_wr      <= 1'b0;
            lock_timeout <= 1'b0;
            if (guard) guard_cnt <= guard_cnt - 2'd1;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= winner;
                        owner_valid <= 1'b1;
                        tcnt        <= '0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        uart_wr      <= 1'b1;
                        uart_tx_data <= own_data;
                        guard_cnt    <= 2'd2;
                        tcnt         <= '0;
                        if (own_last) begin
                            state       <= IDLE;
                            owner_valid <= 1'b0;
                            rr_ptr      <= next_ptr;
                        end
                    end else if (idle_cycle) begin
                        if (TIMEOUT > 0 && tcnt == TLAST) begin
                            lock_timeout <= 1'b1;
                            state        <= IDLE;
                            owner_valid  <= 1'b0;
                            rr_ptr       <= next_ptr;
                            tcnt         <= '0;
                        end else if (tcnt != '1) begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a buart busy model and a
// message-level round-robin reference that predicts the byte order on the wire.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TMO = 16;

    logic             clk = 1'b0;
    logic             resetq;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             uart_busy;
    logic             uart_wr;
    logic [7:0]       uart_tx_data;
    logic [IDW-1:0]   owner;
    logic             owner_valid;
    logic             lock_timeout;

    uart_tx_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .resetq       (resetq),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_busy    (uart_busy),
        .uart_wr      (uart_wr),
        .uart_tx_data (uart_tx_data),
        .owner        (owner),
        .owner_valid  (owner_valid),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    // rq[i] holds requester i's pending bytes as {last, data}; exp_q holds {last, owner, data}.
    logic [8:0]   rq [N][$];
    logic [10:0]  exp_q [$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_ptr    = 0;
    int   frame_cnt = 0;
    int   since_acc = 100;
    int   idle_cnt  = 0;
    int   wr_count  = 0;
    int   lt_count  = 0;
    logic ext_busy    = 1'b0;
    logic prev_accept = 1'b0;
    logic to_fire     = 1'b0;

    // Per-cycle driver, busy model and monitor; all checks sit away from posedge.
    initial begin : bench_loop
        logic [10:0]  e, g;
        logic [N-1:0] exp_rdy;
        logic [8:0]   hd;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (resetq) begin
                if (uart_wr) begin
                    wr_count++;
                    n_checks++;
                    g = {~owner_valid, owner, uart_tx_data};
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL wire_byte: unexpected write got %h, required none", g);
                    end else begin
                        e = exp_q.pop_front();
                        if (g !== e) begin
                            n_fail++;
                            $display("FAIL wire_byte: got {last,owner,data}=%h required %h", g, e);
                        end
                    end
                end
                n_checks++;
                if (lock_timeout !== to_fire) begin
                    n_fail++;
                    $display("FAIL lock_timeout: got %b required %b", lock_timeout, to_fire);
                end
                if (lock_timeout) lt_count++;
            end
            if (frame_cnt > 0) frame_cnt--;
            if (resetq && uart_wr) frame_cnt = $urandom_range(3, 12);
            uart_busy = (frame_cnt > 0) || ext_busy;
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) begin
                    hd = rq[i][0];
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = hd[7:0];
                    req_last[i]       = hd[8];
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i]       = 1'($urandom);
                end
            end
            #1;
            if (!resetq) begin
                since_acc   = 100;
                prev_accept = 1'b0;
                idle_cnt    = 0;
                to_fire     = 1'b0;
                frame_cnt   = 0;
            end else begin
                since_acc = prev_accept ? 1 : (since_acc < 100 ? since_acc + 1 : since_acc);
                exp_rdy = '0;
                if (owner_valid && !uart_busy && since_acc >= 3) exp_rdy[owner] = 1'b1;
                n_checks++;
                if (req_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL req_ready: got %b required %b", req_ready, exp_rdy);
                end
                prev_accept = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        void'(rq[i].pop_front());
                        prev_accept = 1'b1;
                    end
                end
                if (!owner_valid || prev_accept) idle_cnt = 0;
                else if (!req_valid[owner] && !uart_busy && since_acc >= 3) idle_cnt++;
                to_fire = owner_valid && (idle_cnt == TMO);
            end
        end
    end

    // Reference: whole messages granted round-robin from m_ptr among requesters with data.
    task automatic build_expected();
        logic [8:0] cq [N][$];
        logic [8:0] b;
        int w;
        for (int i = 0; i < N; i++) cq[i] = rq[i];
        for (int n = 0; n < 1000; n++) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int j = (m_ptr + k) % N;
                if (w < 0 && cq[j].size() > 0) w = j;
            end
            if (w < 0) break;
            do begin
                b = cq[w].pop_front();
                exp_q.push_back({b[8], IDW'(w), b[7:0]});
            end while (!b[8] && cq[w].size() > 0);
            m_ptr = (w + 1) % N;
        end
    endtask

    function automatic int rq_total();
        int t = 0;
        for (int i = 0; i < N; i++) t += rq[i].size();
        return t;
    endfunction

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || owner_valid || rq_total() != 0) && c < budget) begin
            @(negedge clk); #2;
            c++;
        end
        n_checks++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL drain: %0d bytes still expected, %0d queued, required 0", exp_q.size(), rq_total());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        logic [IDW+12:0] got;
        got = {uart_wr, uart_tx_data, owner, owner_valid, lock_timeout, req_ready};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL %s: got wr/data/owner/ov/lt/ready=%h required 0", tag, got);
        end
    endtask

    task automatic test_reset();
        resetq = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_idle_outputs("reset_state");
        resetq = 1'b1;
    endtask

    task automatic test_single_byte();
        @(negedge clk); #2;
        rq[2].push_back({1'b1, 8'h41});
        build_expected();
        @(negedge clk); #2;
        n_checks++;
        if (owner_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_pre_grant: owner_valid got %b required 0", owner_valid);
        end
        @(negedge clk); #2;
        n_checks++;
        if ({owner_valid, owner, req_ready} !== {1'b1, 2'd2, 4'b0100}) begin
            n_fail++; $display("FAIL single_grant: ov/owner/ready got %b/%0d/%b required 1/2/0100", owner_valid, owner, req_ready);
        end
        @(negedge clk); #2;
        n_checks++;
        if ({uart_wr, uart_tx_data, owner_valid} !== {1'b1, 8'h41, 1'b0}) begin
            n_fail++; $display("FAIL single_write: wr/data/ov got %b/%h/%b required 1/41/0", uart_wr, uart_tx_data, owner_valid);
        end
        @(negedge clk); #2;
        n_checks++;
        if (uart_wr !== 1'b0) begin
            n_fail++; $display("FAIL single_wr_pulse: wr got %b required 0", uart_wr);
        end
        wait_drain(200);
    endtask

    task automatic test_atomic();
        rq[0].push_back({1'b0, 8'h41});
        rq[0].push_back({1'b1, 8'h42});
        rq[1].push_back({1'b0, 8'h78});
        rq[1].push_back({1'b1, 8'h79});
        build_expected();
        wait_drain(500);
    endtask

    task automatic test_fairness();
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(16 * i + m)});
        build_expected();
        wait_drain(2000);
    endtask

    task automatic test_busy_pacing();
        int w0;
        @(negedge clk); #2;
        ext_busy = 1'b1;
        @(negedge clk); #2;
        rq[0].push_back({1'b1, 8'h5A});
        build_expected();
        w0 = wr_count;
        repeat (500) @(negedge clk);
        #2;
        n_checks++;
        if (wr_count !== w0 || rq[0].size() !== 1) begin
            n_fail++; $display("FAIL busy_hold: writes got %0d queued %0d required 0 and 1", wr_count - w0, rq[0].size());
        end
        n_checks++;
        if ({owner_valid, owner} !== {1'b1, 2'd0}) begin
            n_fail++; $display("FAIL busy_owner: ov/owner got %b/%0d required 1/0", owner_valid, owner);
        end
        ext_busy = 1'b0;
        @(negedge clk);
        @(negedge clk); #2;
        n_checks++;
        if ({uart_wr, uart_tx_data} !== {1'b1, 8'h5A}) begin
            n_fail++; $display("FAIL busy_release: wr/data got %b/%h required 1/5a", uart_wr, uart_tx_data);
        end
        wait_drain(200);
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                for (int m = $urandom_range(0, 3); m > 0; m--) begin
                    len = $urandom_range(1, 4);
                    for (int b = 1; b <= len; b++) rq[i].push_back({b == len, 8'($urandom)});
                end
            end
            build_expected();
            wait_drain(20000);
        end
    endtask

    task automatic test_reset_mid_message();
        int c = 0;
        rq[2].push_back({1'b0, 8'hA1});
        rq[2].push_back({1'b1, 8'hA2});
        build_expected();
        do begin
            @(negedge clk); #2;
            c++;
        end while (!prev_accept && c < 200);
        n_checks++;
        if (!prev_accept) begin
            n_fail++; $display("FAIL reset_mid_accept: no accept within %0d cycles", c);
        end
        resetq = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        m_ptr = 0;
        @(negedge clk); #2;
        check_idle_outputs("reset_mid_t1");
        @(negedge clk); #2;
        check_idle_outputs("reset_mid_t2");
        resetq = 1'b1;
        rq[3].push_back({1'b1, 8'hC3});
        rq[0].push_back({1'b1, 8'hC0});
        rq[2].push_back({1'b1, 8'hC2});
        build_expected();
        @(negedge clk);
        @(negedge clk); #2;
        n_checks++;
        if ({owner_valid, owner} !== {1'b1, 2'd0}) begin
            n_fail++; $display("FAIL reset_mid_first_grant: ov/owner got %b/%0d required 1/0", owner_valid, owner);
        end
        wait_drain(500);
    endtask

    task automatic test_timeout();
        int c = 0;
        int lt0 = lt_count;
        rq[1].push_back({1'b0, 8'h55});
        rq[3].push_back({1'b1, 8'h33});
        exp_q.push_back({1'b0, 2'd1, 8'h55});
        exp_q.push_back({1'b1, 2'd3, 8'h33});
        while (lt_count == lt0 && c < 300) begin
            @(negedge clk); #2;
            c++;
        end
        n_checks++;
        if (lt_count == lt0) begin
            n_fail++; $display("FAIL timeout_pulse: none within %0d cycles", c);
        end
        @(negedge clk); #2;
        n_checks++;
        if ({owner_valid, owner} !== {1'b1, 2'd3}) begin
            n_fail++; $display("FAIL timeout_regrant: ov/owner got %b/%0d required 1/3", owner_valid, owner);
        end
        wait_drain(300);
        n_checks++;
        if (lt_count - lt0 !== 1) begin
            n_fail++; $display("FAIL timeout_count: pulses got %0d required 1", lt_count - lt0);
        end
    endtask

    initial begin
        resetq = 1'b0;
        test_reset();
        test_single_byte();
        test_atomic();
        test_fairness();
        test_busy_pacing();
        test_random();
        test_reset_mid_message();
        test_timeout();
        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
